// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x oversampling UART receiver feeding a small byte FIFO,
// with sticky frame, parity and overrun flags.
module uart_rx_core #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [31:0]                   baud_inc_i,
    input  logic                          rx_en_i,
    input  logic                          parity_en_i,
    input  logic                          parity_odd_i,
    input  logic                          uart_rx,
    output logic [7:0]                    rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    input  logic                          flag_clr_i,
    output logic                          frame_err_o,
    output logic                          parity_err_o,
    output logic                          overrun_o,
    output logic                          rx_busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
    } state_t;

    state_t state;
    logic [SYNC_STAGES-1:0] sync;
    logic rxs, rxs_q, fall;
    logic [31:0] acc;
    logic [32:0] acc_sum;
    logic tick, mid, last, maj;
    logic [3:0] cnt;
    logic s7, s8;
    logic [2:0] bidx;
    logic [7:0] shreg;
    logic par_pend;
    logic push, pop, full, wr_ok;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;

    assign rxs     = sync[SYNC_STAGES-1];
    assign fall    = rxs_q & ~rxs;
    assign acc_sum = {1'b0, acc} + {1'b0, baud_inc_i};
    assign tick    = rx_en_i & acc_sum[32];
    assign mid     = tick && (cnt == 4'd9);
    assign last    = tick && (cnt == 4'd15);
    // Tick 9 sample is still live; ticks 7 and 8 were captured earlier.
    assign maj     = (s7 & s8) | (s7 & rxs) | (s8 & rxs);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync  <= '1;
            rxs_q <= 1'b1;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], uart_rx};
            rxs_q <= rxs;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            s7        <= 1'b1;
            s8        <= 1'b1;
            bidx      <= '0;
            shreg     <= '0;
            par_pend  <= 1'b0;
            rx_busy_o <= 1'b0;
        end else if (!rx_en_i) begin
            state     <= IDLE;
            acc       <= '0;
            rx_busy_o <= 1'b0;
        end else begin
            acc <= acc_sum[31:0];
            if (tick) cnt <= cnt + 4'd1;
            if (tick && cnt == 4'd7) s7 <= rxs;
            if (tick && cnt == 4'd8) s8 <= rxs;
            unique case (state)
                IDLE: begin
                    acc <= '0;
                    if (fall) begin
                        state     <= START;
                        cnt       <= '0;
                        bidx      <= '0;
                        par_pend  <= 1'b0;
                        rx_busy_o <= 1'b1;
                    end
                end
                START: begin
                    if (mid && maj) begin
                        state     <= IDLE;
                        rx_busy_o <= 1'b0;
                    end else if (last) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (mid) shreg <= {maj, shreg[7:1]};
                    if (last) begin
                        bidx <= bidx + 3'd1;
                        if (bidx == 3'd7)
                            state <= parity_en_i ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (mid)
                        par_pend <= maj != (parity_odd_i ? ~^shreg : ^shreg);
                    if (last) state <= STOP;
                end
                STOP: begin
                    if (mid) begin
                        state     <= IDLE;
                        rx_busy_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign push  = (state == STOP) && mid;
    assign pop   = rx_valid_o & rx_ready_i;
    assign full  = (count == FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_ok = push & (~full | pop);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (wr_ok && !pop) count <= count + (AW+1)'(1);
            else if (pop && !wr_ok) count <= count - (AW+1)'(1);
            frame_err_o  <= (frame_err_o & ~flag_clr_i) | (push & ~maj);
            parity_err_o <= (parity_err_o & ~flag_clr_i) | (push & par_pend);
            overrun_o    <= (overrun_o & ~flag_clr_i) | (push & full & ~pop);
        end
    end

    assign rx_valid_o   = (count != '0);
    assign rx_data_o    = mem[rd_ptr];
    assign fifo_count_o = count;

endmodule
